// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU sharing sequencer: function codes, FSM states, result width.
package alu_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int RSP_W     = 2 * DEF_WIDTH;

  typedef enum logic [2:0] {
    FN_ADDC = 3'b000,
    FN_ADD  = 3'b001,
    FN_SEXT = 3'b010,
    FN_OR   = 3'b011,
    FN_AND  = 3'b100,
    FN_CAT  = 3'b101,
    FN_MUL  = 3'b110,
    FN_ZERO = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational decode of the single-cycle function codes; the multiply lives in the sequencer.
module alu_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         func,
  output logic [2*WIDTH-1:0] result
);

  logic [WIDTH:0]     carry;
  logic [WIDTH-1:0]   ripple_sum;
  logic [2*WIDTH-1:0] add_sum;

  // Explicit bit-by-bit ripple-carry adder for code 000
  always_comb begin
    carry      = '0;
    ripple_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ripple_sum[i] = a[i] ^ b[i] ^ carry[i];
      carry[i+1]    = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign add_sum = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};

  // Function-code decode; multiply and unused codes return zero here
  always_comb begin
    result = '0;
    case (func)
      FN_ADDC: result = {{(WIDTH-1){1'b0}}, carry[WIDTH], ripple_sum};
      FN_ADD:  result = add_sum;
      FN_SEXT: result = {{WIDTH{b[WIDTH-1]}}, b};
      FN_OR:   result[0] = |{a, b};
      FN_AND:  result[0] = &{a, b};
      FN_CAT:  result = {a, b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_sequencer.sv
// Shares one ALU between two requesters: round-robin arbiter, operand registers,
// single-cycle or shift-add multiply sequencing, and a held valid/ready response.
module alu_share_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               rq0_valid,
  output logic               rq0_ready,
  input  logic [WIDTH-1:0]   rq0_a,
  input  logic [WIDTH-1:0]   rq0_b,
  input  logic [2:0]         rq0_func,
  input  logic               rq1_valid,
  output logic               rq1_ready,
  input  logic [WIDTH-1:0]   rq1_a,
  input  logic [WIDTH-1:0]   rq1_b,
  input  logic [2:0]         rq1_func,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e state, state_next;

  // grant is a registered pointer so neither ready ever depends on any valid
  // combinationally; a lone requester is pointed at one cycle after it appears,
  // and when nobody (or everybody) is asking it rests on the tie winner.
  logic grant, grant_next;
  logic last_grant, last_now;
  logic accept;

  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_func;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_func;
  logic [RW-1:0]    mcand;
  logic [CW-1:0]    count;
  logic [RW-1:0]    core_result;

  assign rq0_ready = resetn && (state == IDLE) && !grant;
  assign rq1_ready = resetn && (state == IDLE) && grant;
  assign accept    = (rq0_valid && rq0_ready) || (rq1_valid && rq1_ready);

  assign sel_a    = grant ? rq1_a    : rq0_a;
  assign sel_b    = grant ? rq1_b    : rq0_b;
  assign sel_func = grant ? rq1_func : rq0_func;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (op_a),
    .b      (op_b),
    .func   (op_func),
    .result (core_result)
  );

  // Pick who the arbiter points at next cycle from current requests and history
  always_comb begin
    last_now = accept ? grant : last_grant;
    if (rq0_valid && !rq1_valid)      grant_next = 1'b0;
    else if (rq1_valid && !rq0_valid) grant_next = 1'b1;
    else                              grant_next = !last_now;
  end

  // Control registers: FSM state, grant pointer, round-robin history
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (accept) last_grant <= grant;
    end
  end

  // Next-state and status outputs of the sequencing FSM
  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_next = (sel_func == FN_MUL) ? MUL : EXEC;
      end
      EXEC: state_next = RESP;
      MUL:  if (count == LAST_ITER) state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, register results, run shift-add multiply in rsp_data
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_a     <= '0;
      op_b     <= '0;
      op_func  <= '0;
      mcand    <= '0;
      count    <= '0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a     <= sel_a;
            op_b     <= sel_b;
            op_func  <= sel_func;
            mcand    <= {{WIDTH{1'b0}}, sel_a};
            count    <= '0;
            rsp_data <= '0;
            rsp_id   <= grant;
          end
        end
        EXEC: rsp_data <= core_result;
        MUL: begin
          if (op_b[count]) rsp_data <= rsp_data + mcand;
          mcand <= mcand << 1;
          count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Self-checking bench: directed cases with literal results plus randomized traffic
// compared every cycle against a transaction-level model of the sequencer.
module tb_alu_share_sequencer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         rq0_valid = 1'b0, rq1_valid = 1'b0;
  logic         rq0_ready, rq1_ready;
  logic [W-1:0] rq0_a = '0, rq0_b = '0, rq1_a = '0, rq1_b = '0;
  logic [2:0]   rq0_func = '0, rq1_func = '0;
  logic         rsp_valid, rsp_id, busy;
  logic         rsp_ready = 1'b1;
  logic [2*W-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_busy = 0;
  int          m_cd = 0;
  bit          m_id = 0;
  logic [7:0]  m_data = '0;
  bit          m_last = 1;
  bit          prev_ok = 0, prev_v0 = 0, prev_v1 = 0;
  bit          acc0 = 0, acc1 = 0;

  alu_share_sequencer #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rq0_valid (rq0_valid),
    .rq0_ready (rq0_ready),
    .rq0_a     (rq0_a),
    .rq0_b     (rq0_b),
    .rq0_func  (rq0_func),
    .rq1_valid (rq1_valid),
    .rq1_ready (rq1_ready),
    .rq1_a     (rq1_a),
    .rq1_b     (rq1_b),
    .rq1_func  (rq1_func),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Result of an op computed from plain integer arithmetic
  function automatic logic [7:0] ref_result(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (f)
      3'd0, 3'd1: return 8'(ia + ib);
      3'd2:       return 8'((ib >= 8) ? ib - 16 : ib);
      3'd3:       return (ia != 0 || ib != 0) ? 8'd1 : 8'd0;
      3'd4:       return (ia == 15 && ib == 15) ? 8'd1 : 8'd0;
      3'd5:       return 8'(ia * 16 + ib);
      3'd6:       return 8'(ia * ib);
      default:    return 8'd0;
    endcase
  endfunction

  // Compare DUT to the transaction model on every falling edge, then advance the model
  always @(negedge clock) begin : compare_proc
    bit exp_valid;
    bit exp_g;
    bit exp_r0, exp_r1;
    if (!resetn) begin
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rq0_ready", rq0_ready, 0);
      check("rst_rq1_ready", rq1_ready, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      m_busy  = 0;
      m_cd    = 0;
      m_last  = 1;
      prev_ok = 0;
      acc0    = 0;
      acc1    = 0;
    end else begin
      exp_valid = m_busy && (m_cd == 0);
      check("rsp_valid", rsp_valid, exp_valid);
      check("busy", busy, m_busy);
      if (exp_valid) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
      end
      check("ready_exclusive", rq0_ready & rq1_ready, 0);
      if (m_busy) begin
        check("rq0_ready_busy", rq0_ready, 0);
        check("rq1_ready_busy", rq1_ready, 0);
      end else if (prev_ok && prev_v0 == rq0_valid && prev_v1 == rq1_valid && (rq0_valid || rq1_valid)) begin
        exp_g  = (rq0_valid && rq1_valid) ? !m_last : rq1_valid;
        exp_r0 = (exp_g == 1'b0);
        exp_r1 = (exp_g == 1'b1);
        check("grant_rq0", rq0_ready, exp_r0);
        check("grant_rq1", rq1_ready, exp_r1);
      end
      acc0 = rq0_valid && rq0_ready;
      acc1 = rq1_valid && rq1_ready;
      if (m_busy) begin
        if (m_cd > 0) m_cd--;
        else if (rsp_ready) m_busy = 0;
      end else if (acc0 || acc1) begin
        m_busy = 1;
        m_id   = acc1;
        m_last = acc1;
        if (acc1) begin
          m_data = ref_result(rq1_a, rq1_b, rq1_func);
          m_cd   = (rq1_func == 3'b110) ? W : 1;
        end else begin
          m_data = ref_result(rq0_a, rq0_b, rq0_func);
          m_cd   = (rq0_func == 3'b110) ? W : 1;
        end
      end
      prev_ok = 1;
      prev_v0 = rq0_valid;
      prev_v1 = rq1_valid;
    end
  end

  task automatic set_req(input bit req, input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    if (req) begin
      rq1_valid = 1'b1; rq1_a = a; rq1_b = b; rq1_func = f;
    end else begin
      rq0_valid = 1'b1; rq0_a = a; rq0_b = b; rq0_func = f;
    end
  endtask

  // One directed op: returns on the falling edge where the response first shows
  task automatic do_op(input bit req, input logic [3:0] a, input logic [3:0] b, input logic [2:0] f,
                       input logic [7:0] exp_data, input int exp_lat, input string name);
    int n;
    bit got;
    @(posedge clock); #2;
    set_req(req, a, b, f);
    got = 0;
    n = 0;
    while (n < 20 && !got) begin
      @(negedge clock);
      n++;
      got = req ? (rq1_valid && rq1_ready) : (rq0_valid && rq0_ready);
    end
    check({name, "_accept"}, got, 1);
    @(posedge clock); #2;
    if (req) rq1_valid = 1'b0; else rq0_valid = 1'b0;
    if (!got) return;
    n = 1;
    got = 0;
    @(negedge clock);
    got = rsp_valid;
    while (n < 20 && !got) begin
      @(negedge clock);
      n++;
      got = rsp_valid;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_data"}, rsp_data, exp_data);
    check({name, "_id"}, rsp_id, req);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      done = !busy && !rsp_valid;
    end
    check({name, "_idle"}, done, 1);
  endtask

  task automatic wait_any_accept(output bit got, output bit who);
    got = 0;
    who = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (rq0_valid && rq0_ready) begin got = 1; who = 0; end
      else if (rq1_valid && rq1_ready) begin got = 1; who = 1; end
    end
  endtask

  task automatic rand_op(input bit req);
    set_req(req, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
  endtask

  task automatic apply_stimulus(input int cycles);
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(posedge clock); #2;
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 149) == 0) resetn = 1'b0;
      if (rq0_valid && acc0) begin
        if ($urandom_range(0, 1) == 1) rand_op(0); else rq0_valid = 1'b0;
      end else if (!rq0_valid && $urandom_range(0, 2) == 0) rand_op(0);
      if (rq1_valid && acc1) begin
        if ($urandom_range(0, 1) == 1) rand_op(1); else rq1_valid = 1'b0;
      end else if (!rq1_valid && $urandom_range(0, 2) == 0) rand_op(1);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #2;
    resetn    = 1'b1;
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("random_drain");
  endtask

  initial begin : main
    bit got, who;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;

    // requester 0 ripple add, then requester 1 multiply
    do_op(0, 4'hF, 4'h1, 3'b000, 8'h10, 2, "t1_addc");
    do_op(1, 4'hF, 4'hF, 3'b110, 8'hE1, 5, "t2_mul");

    // both valid continuously: strict alternation starting with requester 0
    @(posedge clock); #2;
    set_req(0, 4'h1, 4'h2, 3'b001);
    set_req(1, 4'h3, 4'h4, 3'b001);
    for (int k = 0; k < 4; k++) begin
      wait_any_accept(got, who);
      check("t3_accept", got, 1);
      check("t3_order", who, k % 2);
      @(posedge clock); #2;
      if (k == 3) begin
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
      end else if (who) rand_op(1);
      else rand_op(0);
      if (rq0_valid) rq0_func = 3'b001;
      if (rq1_valid) rq1_func = 3'b001;
    end
    wait_idle("t3");

    // consumer stalls: response held stable while rsp_ready is low
    @(posedge clock); #2;
    rsp_ready = 1'b0;
    do_op(0, 4'h7, 4'h6, 3'b110, 8'h2A, 5, "t4_mul");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_data", rsp_data, 8'h2A);
      check("t4_hold_id", rsp_id, 0);
      check("t4_hold_ready", rq0_ready | rq1_ready, 0);
    end
    @(posedge clock); #2;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t4_released", rsp_valid, 0);

    // reset in the middle of a multiply from requester 0
    @(posedge clock); #2;
    set_req(0, 4'hF, 4'hF, 3'b110);
    wait_any_accept(got, who);
    check("t5_mul_accept", got, 1);
    @(posedge clock); #2;
    rq0_valid = 1'b0;
    @(posedge clock); #2;
    resetn = 1'b0;
    set_req(0, 4'h2, 4'h2, 3'b001);
    set_req(1, 4'h5, 4'h5, 3'b001);
    #1;
    check("t5_async_rsp_valid", rsp_valid, 0);
    check("t5_async_busy", busy, 0);
    @(posedge clock); #2;
    resetn = 1'b1;
    wait_any_accept(got, who);
    check("t5_first_accept", got, 1);
    check("t5_first_id", who, 0);
    @(posedge clock); #2;
    rq0_valid = 1'b0;
    wait_any_accept(got, who);
    check("t5_second_id", who, 1);
    @(posedge clock); #2;
    rq1_valid = 1'b0;
    wait_idle("t5");

    // remaining single-cycle codes
    do_op(0, 4'h0, 4'h9, 3'b010, 8'hF9, 2, "t6_sext");
    do_op(0, 4'h3, 4'hC, 3'b101, 8'h3C, 2, "t6_cat");
    do_op(1, 4'h5, 4'h6, 3'b111, 8'h00, 2, "t6_zero");
    do_op(0, 4'h0, 4'h0, 3'b011, 8'h00, 2, "t6_or");
    do_op(1, 4'hF, 4'hF, 3'b100, 8'h01, 2, "t6_and");
    wait_idle("t6");

    apply_stimulus(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
